// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing one line-wide data memory between the
// instruction cache (port 0) and the data cache (port 1), with a sticky watchdog.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_enable_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [LINE_W-1:0] req0_data_i,
  output logic [LINE_W-1:0] req0_data_o,
  output logic              req0_ack_o,
  input  logic              req1_enable_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [LINE_W-1:0] req1_data_i,
  output logic [LINE_W-1:0] req1_data_o,
  output logic              req1_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GNT0 = 2'd1;
  localparam logic [1:0] GNT1 = 2'd2;

  logic [1:0] state_reg, state_next;
  logic       last_grant_reg, last_grant_next;
  logic       gnt0, gnt1;

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        // On a tie the port that did not win last time goes first.
        if (req0_enable_i && req1_enable_i)
          state_next = last_grant_reg ? GNT0 : GNT1;
        else if (req0_enable_i)
          state_next = GNT0;
        else if (req1_enable_i)
          state_next = GNT1;
      end
      GNT0: if (mem_ack_i) begin
        state_next      = IDLE;
        last_grant_next = 1'b0;
      end
      GNT1: if (mem_ack_i) begin
        state_next      = IDLE;
        last_grant_next = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign gnt0         = (state_reg == GNT0);
  assign gnt1         = (state_reg == GNT1);
  assign grant_o      = {gnt1, gnt0};
  assign mem_enable_o = gnt0 | gnt1;
  assign mem_write_o  = (gnt0 & req0_write_i) | (gnt1 & req1_write_i);
  assign mem_addr_o   = gnt0 ? req0_addr_i : (gnt1 ? req1_addr_i : '0);
  assign mem_data_o   = gnt0 ? req0_data_i : (gnt1 ? req1_data_i : '0);
  assign req0_ack_o   = mem_ack_i & gnt0;
  assign req1_ack_o   = mem_ack_i & gnt1;
  assign req0_data_o  = mem_data_i;
  assign req1_data_o  = mem_data_i;

  generate
    if (TIMEOUT_CYC != 0) begin : g_wd
      localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
      logic [15:0] wd_cnt_reg;
      logic        timeout_reg;

      // Counter runs only while a grant is outstanding; the flag never clears
      // short of reset and does not revoke the grant.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wd_cnt_reg  <= '0;
          timeout_reg <= 1'b0;
        end else if (mem_enable_o && !mem_ack_i) begin
          if (wd_cnt_reg != 16'hFFFF)
            wd_cnt_reg <= wd_cnt_reg + 16'd1;
          if (wd_cnt_reg == WD_LAST)
            timeout_reg <= 1'b1;
        end else begin
          wd_cnt_reg <= '0;
        end
      end
      assign timeout_o = timeout_reg;
    end else begin : g_no_wd
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for arbitration/routing plus
// hand-written multi-cycle sequences; instance 1 has an 8-cycle watchdog, instance 2 none.
module tb_dmem_arbiter;

  localparam logic [255:0] DA5 = {32{8'hA5}};
  localparam logic [255:0] D12 = {16{16'h1234}};
  localparam logic [255:0] D0  = {32{8'h5A}};
  localparam logic [31:0]  A0  = 32'h0000_0100;
  localparam logic [31:0]  A1  = 32'h0000_0200;

  logic         clk = 1'b0;
  logic         rst;
  logic         r0_en, r0_wr, r1_en, r1_wr, m_ack;
  logic [31:0]  r0_addr, r1_addr;
  logic [255:0] r0_data, r1_data, m_din;

  logic [255:0] d0o [3];
  logic [255:0] d1o [3];
  logic [255:0] mdo [3];
  logic [31:0]  mao [3];
  logic         k0 [3];
  logic         k1 [3];
  logic         men [3];
  logic         mwr [3];
  logic         tmo [3];
  logic [1:0]   gnt [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      dmem_arbiter #(
        .ADDR_W(32), .LINE_W(256),
        .TIMEOUT_CYC((gi == 0) ? 1024 : ((gi == 1) ? 8 : 0))
      ) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_enable_i(r0_en), .req0_write_i(r0_wr), .req0_addr_i(r0_addr),
        .req0_data_i(r0_data), .req0_data_o(d0o[gi]), .req0_ack_o(k0[gi]),
        .req1_enable_i(r1_en), .req1_write_i(r1_wr), .req1_addr_i(r1_addr),
        .req1_data_i(r1_data), .req1_data_o(d1o[gi]), .req1_ack_o(k1[gi]),
        .mem_enable_o(men[gi]), .mem_write_o(mwr[gi]), .mem_addr_o(mao[gi]),
        .mem_data_o(mdo[gi]), .mem_data_i(m_din), .mem_ack_i(m_ack),
        .grant_o(gnt[gi]), .timeout_o(tmo[gi])
      );
    end
  endgenerate

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0;
    logic        r1, w1;
    logic [31:0] a1;
    logic        ack;
    logic [1:0]  e_g;
    logic        e_k0, e_k1, e_men, e_mwr;
    logic [31:0] e_ma;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_en = 0; r0_wr = 0; r0_addr = '0; r0_data = D0;
    r1_en = 0; r1_wr = 0; r1_addr = '0; r1_data = D12;
    m_ack = 0; m_din = DA5;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    #1;
    do_reset();
    chk("rst_grant", 256'(gnt[0]), 256'(2'b00));
    chk("rst_men", 256'(men[0]), 256'(0));
    chk("rst_mwr", 256'(mwr[0]), 256'(0));
    chk("rst_ack0", 256'(k0[0]), 256'(0));
    chk("rst_ack1", 256'(k1[0]), 256'(0));
    chk("rst_tmo", 256'(tmo[0]), 256'(0));
    chk("rst_mdata", mdo[0], 256'(0));

    // Vector table: contested round-robin, ack while idle, writes on each port.
    //           r0 w0 a0  r1 w1 a1  ack  grant  k0 k1 men mwr addr
    vt[0]  = '{1, 0, A0, 1, 0, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[1]  = '{1, 0, A0, 1, 0, A1, 1, 2'b01, 1, 0, 1, 0, A0};
    vt[2]  = '{1, 0, A0, 1, 0, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[3]  = '{1, 0, A0, 1, 0, A1, 1, 2'b10, 0, 1, 1, 0, A1};
    vt[4]  = '{1, 0, A0, 1, 0, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[5]  = '{1, 0, A0, 1, 0, A1, 1, 2'b01, 1, 0, 1, 0, A0};
    vt[6]  = '{1, 0, A0, 1, 0, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[7]  = '{1, 0, A0, 1, 0, A1, 1, 2'b10, 0, 1, 1, 0, A1};
    vt[8]  = '{0, 0, A0, 0, 0, A1, 1, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[9]  = '{0, 0, A0, 0, 0, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[10] = '{0, 0, A0, 1, 1, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[11] = '{0, 0, A0, 1, 1, A1, 0, 2'b10, 0, 0, 1, 1, A1};
    vt[12] = '{0, 0, A0, 1, 1, A1, 1, 2'b10, 0, 1, 1, 1, A1};
    vt[13] = '{1, 1, A0, 0, 0, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};
    vt[14] = '{1, 1, A0, 0, 0, A1, 1, 2'b01, 1, 0, 1, 1, A0};
    vt[15] = '{0, 0, A0, 0, 0, A1, 0, 2'b00, 0, 0, 0, 0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      logic [255:0] e_md;
      r0_en = vt[i].r0; r0_wr = vt[i].w0; r0_addr = vt[i].a0;
      r1_en = vt[i].r1; r1_wr = vt[i].w1; r1_addr = vt[i].a1;
      m_ack = vt[i].ack;
      #1;
      e_md = (vt[i].e_g == 2'b01) ? D0 : ((vt[i].e_g == 2'b10) ? D12 : '0);
      chk($sformatf("v%0d_grant", i), 256'(gnt[0]), 256'(vt[i].e_g));
      chk($sformatf("v%0d_ack0", i), 256'(k0[0]), 256'(vt[i].e_k0));
      chk($sformatf("v%0d_ack1", i), 256'(k1[0]), 256'(vt[i].e_k1));
      chk($sformatf("v%0d_men", i), 256'(men[0]), 256'(vt[i].e_men));
      chk($sformatf("v%0d_mwr", i), 256'(mwr[0]), 256'(vt[i].e_mwr));
      chk($sformatf("v%0d_maddr", i), 256'(mao[0]), 256'(vt[i].e_ma));
      chk($sformatf("v%0d_mdata", i), mdo[0], e_md);
      $display("vec %0d: grant=%b ack0=%b ack1=%b addr=%h", i, gnt[0], k0[0], k1[0], mao[0]);
      step();
    end

    // Single read from port 0 with a 10-cycle memory latency.
    do_reset();
    r0_en = 1; r0_addr = 32'h0000_0400;
    step();
    chk("rd_grant", 256'(gnt[0]), 256'(2'b01));
    chk("rd_addr", 256'(mao[0]), 256'(32'h400));
    chk("rd_wr", 256'(mwr[0]), 256'(0));
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("rd_wait%0d_ack0", c), 256'(k0[0]), 256'(0));
      step();
    end
    m_ack = 1;
    #1;
    chk("rd_ack0", 256'(k0[0]), 256'(1));
    chk("rd_ack1", 256'(k1[0]), 256'(0));
    chk("rd_data0", d0o[0], DA5);
    chk("rd_data1", d1o[0], DA5);
    step();
    m_ack = 0; r0_en = 0;
    #1;
    chk("rd_idle_grant", 256'(gnt[0]), 256'(2'b00));
    chk("rd_idle_ack0", 256'(k0[0]), 256'(0));
    $display("seq read: done");

    // Port 1 writeback then refill while port 0 waits: GNT1(wr), GNT0, GNT1(rd).
    do_reset();
    r1_en = 1; r1_wr = 1; r1_addr = 32'h0000_7C00;
    step();
    r0_en = 1; r0_addr = A0;
    #1;
    chk("wb_grant", 256'(gnt[0]), 256'(2'b10));
    chk("wb_wr", 256'(mwr[0]), 256'(1));
    chk("wb_addr", 256'(mao[0]), 256'(32'h7C00));
    chk("wb_data", mdo[0], D12);
    m_ack = 1;
    #1;
    chk("wb_ack1", 256'(k1[0]), 256'(1));
    chk("wb_ack0", 256'(k0[0]), 256'(0));
    step();
    m_ack = 0; r1_wr = 0; r1_addr = 32'h0000_0C00;
    #1;
    chk("wb_gap", 256'(gnt[0]), 256'(2'b00));
    step();
    chk("wb_p0_grant", 256'(gnt[0]), 256'(2'b01));
    chk("wb_p0_addr", 256'(mao[0]), 256'(A0));
    m_ack = 1;
    step();
    m_ack = 0; r0_en = 0;
    step();
    chk("rf_grant", 256'(gnt[0]), 256'(2'b10));
    chk("rf_wr", 256'(mwr[0]), 256'(0));
    chk("rf_addr", 256'(mao[0]), 256'(32'hC00));
    m_ack = 1;
    step();
    m_ack = 0; r1_en = 0;
    $display("seq writeback/refill: done");

    // Reset while port 1 owns memory; a late ack must not be routed.
    do_reset();
    r1_en = 1; r1_addr = A1;
    step();
    chk("rm_grant", 256'(gnt[0]), 256'(2'b10));
    r1_en = 0;
    rst = 1;
    step();
    rst = 0;
    m_ack = 1;
    #1;
    chk("rm_men", 256'(men[0]), 256'(0));
    chk("rm_grant0", 256'(gnt[0]), 256'(2'b00));
    chk("rm_ack0", 256'(k0[0]), 256'(0));
    chk("rm_ack1", 256'(k1[0]), 256'(0));
    step();
    m_ack = 0;
    #1;
    chk("rm_still_idle", 256'(gnt[0]), 256'(2'b00));
    $display("seq reset mid-grant: done");

    // Watchdog: instance 1 times out after 8 grant cycles, instance 2 never.
    do_reset();
    r0_en = 1; r0_addr = A0;
    for (int c = 1; c <= 8; c++) begin
      step();
      chk($sformatf("wd_c%0d_t8", c), 256'(tmo[1]), 256'(0));
    end
    step();
    chk("wd_t8_set", 256'(tmo[1]), 256'(1));
    chk("wd_t8_grant_kept", 256'(gnt[1]), 256'(2'b01));
    chk("wd_t0_clear", 256'(tmo[2]), 256'(0));
    chk("wd_t1024_clear", 256'(tmo[0]), 256'(0));
    m_ack = 1;
    step();
    m_ack = 0; r0_en = 0;
    step();
    chk("wd_t8_sticky", 256'(tmo[1]), 256'(1));
    chk("wd_t8_idle", 256'(gnt[1]), 256'(2'b00));
    chk("wd_t0_never", 256'(tmo[2]), 256'(0));
    $display("seq watchdog: done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
